// File: rtl/booth_pkg.sv
// Shared widths and types for the radix-8 Booth operand preparation stage.
package booth_pkg;
  localparam int MAG_W      = 7;
  localparam int X3_W       = 9;
  localparam int X5_W       = 10;
  localparam int X7_W       = 10;
  localparam int DIGIT_W    = 3;
  localparam int NUM_DIGITS = 2;

  typedef logic [NUM_DIGITS-1:0][MAG_W-1:0] booth_sel_t;

  typedef struct packed {
    logic [MAG_W-1:0] dat1x;
    logic [X3_W-1:0]  dat3x;
    logic [X5_W-1:0]  dat5x;
    logic [X7_W-1:0]  dat7x;
    logic             neg_a;
    logic             neg_b;
    booth_sel_t       sel;
    logic             high_bit;
  } prep_set_t;

  // Sign-magnitude negative zero reports as non-negative.
  function automatic logic neg_flag(input logic [MAG_W:0] v);
    return v[MAG_W] & (|v[MAG_W-1:0]);
  endfunction
endpackage

// File: rtl/booth_prep_stage_if.sv
// Operand-in / prepared-set-out handshake bundle for booth_prep_stage.
interface booth_prep_stage_if #(parameter int CNT_W = 8);
  import booth_pkg::*;

  logic              iValid;
  logic              oReady;
  logic [MAG_W:0]    iA;
  logic [MAG_W:0]    iB;
  logic              iFlush;
  logic              oValid;
  logic              iReady;
  logic [MAG_W-1:0]  oDat1X;
  logic [X3_W-1:0]   oDat3X;
  logic [X5_W-1:0]   oDat5X;
  logic [X7_W-1:0]   oDat7X;
  logic              oNegativeA;
  logic              oNegativeB;
  booth_sel_t        oBoothSel;
  logic              oHighBit;
  logic [CNT_W-1:0]  oCount;

  modport slave (
    input  iValid, iA, iB, iFlush, iReady,
    output oReady, oValid, oDat1X, oDat3X, oDat5X, oDat7X,
           oNegativeA, oNegativeB, oBoothSel, oHighBit, oCount
  );

  modport master (
    output iValid, iA, iB, iFlush, iReady,
    input  oReady, oValid, oDat1X, oDat3X, oDat5X, oDat7X,
           oNegativeA, oNegativeB, oBoothSel, oHighBit, oCount
  );
endinterface

// File: rtl/booth_digit_enc.sv
// One radix-8 digit (0..7) to a one-hot select over the multiples 1..7; digit 0 selects nothing.
module booth_digit_enc
  import booth_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [MAG_W-1:0]   sel_o
);
  always_comb begin
    sel_o = '0;
    for (int k = 0; k < MAG_W; k++) sel_o[k] = (digit_i == DIGIT_W'(k + 1));
  end
endmodule

// File: rtl/booth_prep_stage.sv
// Two-stage elastic pipeline: S1 captures the operands, S2 holds the prepared multiples and selects.
module booth_prep_stage
  import booth_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input logic               iClk,
  input logic               iRst,
  booth_prep_stage_if.slave bus
);
  // vld_pipe_q[0] = S1 valid, vld_pipe_q[1] = S2 valid
  logic [1:0]       vld_pipe_q;
  logic [MAG_W:0]   a_q, b_q;
  prep_set_t        set_q, set_d;
  logic [CNT_W-1:0] count_q;

  logic s2_free, s2_load, s1_free, accept, xfer;
  logic [MAG_W-1:0] mag_a, mag_b;
  booth_sel_t       sel;

  assign xfer    = vld_pipe_q[1] & bus.iReady;
  assign s2_free = !vld_pipe_q[1] | bus.iReady;
  assign s2_load = vld_pipe_q[0] & s2_free;
  assign s1_free = !vld_pipe_q[0] | s2_load;
  // Depends only on state, iReady, iFlush and iRst: never on iValid.
  assign bus.oReady = s1_free & !bus.iFlush & !iRst;
  assign accept     = bus.iValid & bus.oReady;

  assign mag_a = a_q[MAG_W-1:0];
  assign mag_b = b_q[MAG_W-1:0];

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
    booth_digit_enc u_enc (
      .digit_i (mag_b[d*DIGIT_W +: DIGIT_W]),
      .sel_o   (sel[d])
    );
  end

  always_comb begin
    set_d          = '0;
    set_d.dat1x    = mag_a;
    set_d.dat3x    = {2'b0, mag_a} + {1'b0, mag_a, 1'b0};
    set_d.dat5x    = {3'b0, mag_a} + {1'b0, mag_a, 2'b0};
    set_d.dat7x    = {mag_a, 3'b0} - {3'b0, mag_a};
    set_d.neg_a    = neg_flag(a_q);
    set_d.neg_b    = neg_flag(b_q);
    set_d.sel      = sel;
    set_d.high_bit = mag_b[MAG_W-1];
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      vld_pipe_q <= '0;
      count_q    <= '0;
    end else begin
      if (xfer) count_q <= count_q + CNT_W'(1);
      if (bus.iFlush) begin
        vld_pipe_q <= '0;
      end else begin
        if (s2_free) vld_pipe_q[1] <= vld_pipe_q[0];
        if (s1_free) vld_pipe_q[0] <= accept;
      end
    end
  end

  // Data registers carry no reset; the valid bits qualify them.
  always_ff @(posedge iClk) begin
    if (accept) begin
      a_q <= bus.iA;
      b_q <= bus.iB;
    end
    if (s2_load) set_q <= set_d;
  end

  assign bus.oValid     = vld_pipe_q[1];
  assign bus.oDat1X     = set_q.dat1x;
  assign bus.oDat3X     = set_q.dat3x;
  assign bus.oDat5X     = set_q.dat5x;
  assign bus.oDat7X     = set_q.dat7x;
  assign bus.oNegativeA = set_q.neg_a;
  assign bus.oNegativeB = set_q.neg_b;
  assign bus.oBoothSel  = set_q.sel;
  assign bus.oHighBit   = set_q.high_bit;
  assign bus.oCount     = count_q;
endmodule

// File: tb/tb_booth_prep_stage.sv
// Directed bench for booth_prep_stage: datapath values, stalls, flush, reset and counter wrap.
module tb_booth_prep_stage;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  booth_prep_stage_if #(.CNT_W(8)) bus ();

  booth_prep_stage #(.CNT_W(8)) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b);
    bus.iValid = v;
    bus.iA     = a;
    bus.iB     = b;
  endtask

  initial begin
    rst = 1'b1;
    bus.iFlush = 1'b0;
    bus.iReady = 1'b1;
    drive(1'b0, 8'h00, 8'h00);
    tick();
    tick();
    chk("rst_ovalid", bus.oValid, 0);
    chk("rst_count", bus.oCount, 0);
    chk("rst_oready", bus.oReady, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_oready", bus.oReady, 1);

    // 0x05 x 0xFF, latency of two edges
    drive(1'b1, 8'h05, 8'hFF);
    tick();
    drive(1'b0, 8'h00, 8'h00);
    chk("lat_not_yet", bus.oValid, 0);
    tick();
    chk("v1_valid", bus.oValid, 1);
    chk("v1_1x", bus.oDat1X, 5);
    chk("v1_3x", bus.oDat3X, 15);
    chk("v1_5x", bus.oDat5X, 25);
    chk("v1_7x", bus.oDat7X, 35);
    chk("v1_nega", bus.oNegativeA, 0);
    chk("v1_negb", bus.oNegativeB, 1);
    chk("v1_sel", bus.oBoothSel, 14'h2040);
    chk("v1_hb", bus.oHighBit, 1);
    tick();
    chk("v1_done", bus.oValid, 0);
    chk("v1_count", bus.oCount, 1);

    // back-to-back: negative zero, then full-scale negative magnitude
    drive(1'b1, 8'h80, 8'h2A);
    tick();
    drive(1'b1, 8'hFF, 8'h80);
    tick();
    drive(1'b0, 8'h00, 8'h00);
    chk("v2_valid", bus.oValid, 1);
    chk("v2_1x", bus.oDat1X, 0);
    chk("v2_7x", bus.oDat7X, 0);
    chk("v2_nega", bus.oNegativeA, 0);
    chk("v2_negb", bus.oNegativeB, 0);
    chk("v2_sel", bus.oBoothSel, 14'h0802);
    chk("v2_hb", bus.oHighBit, 0);
    tick();
    chk("v3_valid", bus.oValid, 1);
    chk("v3_3x", bus.oDat3X, 381);
    chk("v3_5x", bus.oDat5X, 635);
    chk("v3_7x", bus.oDat7X, 889);
    chk("v3_nega", bus.oNegativeA, 1);
    chk("v3_negb", bus.oNegativeB, 0);
    chk("v3_sel", bus.oBoothSel, 0);
    tick();
    chk("v3_done", bus.oValid, 0);
    chk("v3_count", bus.oCount, 3);

    // stall with both stages full
    bus.iReady = 1'b0;
    drive(1'b1, 8'h01, 8'h01);
    tick();
    drive(1'b1, 8'h02, 8'h02);
    tick();
    drive(1'b1, 8'h03, 8'h03);
    #1;
    chk("stall_oready", bus.oReady, 0);
    tick();
    chk("stall_valid", bus.oValid, 1);
    chk("stall_hold1", bus.oDat1X, 1);
    tick();
    chk("stall_hold2", bus.oDat1X, 1);
    chk("stall_oready2", bus.oReady, 0);
    bus.iReady = 1'b1;
    #1;
    chk("release_oready", bus.oReady, 1);
    tick();
    chk("order_2", bus.oDat1X, 2);
    drive(1'b1, 8'h04, 8'h04);
    tick();
    drive(1'b0, 8'h00, 8'h00);
    chk("order_3", bus.oDat1X, 3);
    tick();
    chk("order_4", bus.oDat1X, 4);
    chk("order_4_valid", bus.oValid, 1);
    tick();
    chk("stall_done", bus.oValid, 0);
    chk("stall_count", bus.oCount, 7);

    // flush with both stages full and a set offered
    bus.iReady = 1'b0;
    drive(1'b1, 8'h10, 8'h00);
    tick();
    drive(1'b1, 8'h11, 8'h00);
    tick();
    drive(1'b1, 8'h12, 8'h00);
    bus.iFlush = 1'b1;
    #1;
    chk("flush_oready", bus.oReady, 0);
    tick();
    bus.iFlush = 1'b0;
    drive(1'b0, 8'h00, 8'h00);
    chk("flush_ovalid", bus.oValid, 0);
    chk("flush_count", bus.oCount, 7);
    #1;
    chk("flush_s1_empty", bus.oReady, 1);
    tick();
    chk("flush_no_accept", bus.oValid, 0);

    // transfer coinciding with flush still counts
    bus.iReady = 1'b1;
    drive(1'b1, 8'h20, 8'h00);
    tick();
    drive(1'b0, 8'h00, 8'h00);
    tick();
    chk("fx_valid", bus.oValid, 1);
    bus.iFlush = 1'b1;
    tick();
    bus.iFlush = 1'b0;
    chk("fx_ovalid", bus.oValid, 0);
    chk("fx_count", bus.oCount, 8);

    // reset with both stages full
    bus.iReady = 1'b0;
    drive(1'b1, 8'h30, 8'h00);
    tick();
    drive(1'b1, 8'h31, 8'h00);
    tick();
    drive(1'b0, 8'h00, 8'h00);
    rst = 1'b1;
    #1;
    chk("mrst_oready", bus.oReady, 0);
    tick();
    chk("mrst_ovalid", bus.oValid, 0);
    chk("mrst_count", bus.oCount, 0);
    rst = 1'b0;
    #1;
    chk("mrst_oready_after", bus.oReady, 1);
    tick();
    chk("mrst_no_spurious", bus.oValid, 0);

    // counter wrap: 256 transfers then one more
    bus.iReady = 1'b1;
    drive(1'b1, 8'h01, 8'h00);
    repeat (100) tick();
    chk("wrap_mid", bus.oCount, 98);
    repeat (156) tick();
    drive(1'b0, 8'h00, 8'h00);
    tick();
    tick();
    chk("wrap_256", bus.oCount, 0);
    chk("wrap_idle", bus.oValid, 0);
    drive(1'b1, 8'h01, 8'h00);
    tick();
    drive(1'b0, 8'h00, 8'h00);
    tick();
    tick();
    chk("wrap_257", bus.oCount, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
